// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port synchronous RAM between an instruction-fetch port
//   and a data (LSU) port. At most one side is granted per cycle. A lone
//   requester is always granted. Under contention the side that did not win
//   the previous contended cycle wins. The RAM port is driven from the
//   granted side, and rvalid returns to that side one cycle later.
//   Cycles with both requests high are counted in a saturating counter.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   instr_req_i/addr_i        fetch request and word-aligned byte address
//   instr_gnt_o               fetch granted this cycle (combinational)
//   instr_rvalid_o/rdata_o    fetch response, one cycle after the grant
//   data_req_i/addr_i/we_i/be_i/wdata_i
//                             LSU request; we=1 marks a write
//   data_gnt_o                LSU granted this cycle (combinational)
//   data_rvalid_o/rdata_o     LSU response, one cycle after the grant
//                             (also issued for writes)
//   mem_en_o/addr_o/we_o/be_o/wdata_o
//                             single-port RAM request
//   mem_rdata_i               RAM read data, valid the cycle after mem_en_o
//   conflict_cnt_o            saturating count of contended cycles
// ----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_WIDTH = 22
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,

   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,

   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i,

   output logic [31:0]           conflict_cnt_o
);

   typedef enum logic {
      SIDE_INSTR = 1'b0,
      SIDE_DATA  = 1'b1
   } side_e;

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
      logic [3:0]            be;
      logic [31:0]           wdata;
   } mem_req_t;

   side_e       last;          // winner of the most recent contended cycle
   logic        rv_instr;
   logic        rv_data;
   logic [31:0] conflict_cnt;
   logic        both;
   logic        gnt_instr;
   logic        gnt_data;
   mem_req_t    mem_req;

   assign both = instr_req_i & data_req_i;

   // A lone request always wins. On a tie the side that lost last time wins,
   // so sustained contention alternates 1:1.
   always_comb begin
      gnt_instr = 1'b0;
      gnt_data  = 1'b0;
      if (both) begin
         gnt_instr = (last == SIDE_DATA);
         gnt_data  = (last == SIDE_INSTR);
      end else begin
         gnt_instr = instr_req_i;
         gnt_data  = data_req_i;
      end
   end

   assign instr_gnt_o = gnt_instr;
   assign data_gnt_o  = gnt_data;

   // RAM port mux. Fetches are always full-word reads. An idle port is driven
   // to all-zero so the macro sees no stray address or data toggling.
   always_comb begin
      mem_req = '0;
      if (gnt_instr) begin
         mem_req.en    = 1'b1;
         mem_req.addr  = instr_addr_i;
         mem_req.we    = 1'b0;
         mem_req.be    = 4'b1111;
         mem_req.wdata = '0;
      end else if (gnt_data) begin
         mem_req.en    = 1'b1;
         mem_req.addr  = data_addr_i;
         mem_req.we    = data_we_i;
         mem_req.be    = data_be_i;
         mem_req.wdata = data_wdata_i;
      end
   end

   assign mem_en_o    = mem_req.en;
   assign mem_addr_o  = mem_req.addr;
   assign mem_we_o    = mem_req.we;
   assign mem_be_o    = mem_req.be;
   assign mem_wdata_o = mem_req.wdata;

   // Arbitration history: updated only on contended cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= SIDE_DATA;
      end else if (both) begin
         last <= gnt_instr ? SIDE_INSTR : SIDE_DATA;
      end
   end

   // Response pipeline. The grants are one-hot, so the two rvalids are as well.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_instr <= 1'b0;
         rv_data  <= 1'b0;
      end else begin
         rv_instr <= gnt_instr;
         rv_data  <= gnt_data;
      end
   end

   assign instr_rvalid_o = rv_instr;
   assign data_rvalid_o  = rv_data;

   // The RAM read data goes to both sides; the matching rvalid qualifies it.
   assign instr_rdata_o = mem_rdata_i;
   assign data_rdata_o  = mem_rdata_i;

   // Saturating conflict counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (both && (conflict_cnt != 32'hFFFF_FFFF)) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

   assign conflict_cnt_o = conflict_cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_req = 1'b0;
   logic [AW-1:0] instr_addr = '0;
   logic          instr_gnt, instr_rvalid;
   logic [31:0]   instr_rdata;
   logic          data_req = 1'b0;
   logic [AW-1:0] data_addr = '0;
   logic          data_we = 1'b0;
   logic [3:0]    data_be = '0;
   logic [31:0]   data_wdata = '0;
   logic          data_gnt, data_rvalid;
   logic [31:0]   data_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;
   logic [31:0]   conflict_cnt;

   ram_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .conflict_cnt_o(conflict_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model (word array, byte-enabled writes) -----------
   logic [31:0]   ram [0:1023];
   logic          s_en, s_we;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_be;
   logic [31:0]   s_wdata;

   // Latch the request mid-cycle so the edge never races the comb mux.
   always @(negedge clk) begin
      #3;
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_be = mem_be; s_wdata = mem_wdata;
   end

   always @(posedge clk) begin
      if (s_en) begin
         if (s_we) begin
            for (int b = 0; b < 4; b++)
               if (s_be[b]) ram[s_addr[11:2]][8*b +: 8] = s_wdata[8*b +: 8];
         end else begin
            mem_rdata = ram[s_addr[11:2]];
         end
      end
   end

   // ---------------- scoreboard -------------------------------------------
   typedef struct {
      logic        chk;
      logic [31:0] val;
      int          gcyc;
   } exp_t;

   exp_t qi[$];
   exp_t qd[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever an rvalid is seen and checks both
   // the data and the one-cycle response latency.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (!rst) begin
         if (instr_rvalid && data_rvalid) begin
            tests++; fails++;
            $display("FAIL both_rvalid: got 1 expected 0 (cycle %0d)", cyc);
         end
         if (instr_rvalid) begin
            tests++;
            if (qi.size() == 0) begin
               fails++;
               $display("FAIL instr_spurious_rvalid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = qi.pop_front();
               if (cyc != e.gcyc + 1 || (e.chk && instr_rdata !== e.val)) begin
                  fails++;
                  $display("FAIL instr_resp: got %h@%0d expected %h@%0d", instr_rdata, cyc, e.val, e.gcyc + 1);
               end
            end
         end else if (qi.size() > 0 && qi[0].gcyc + 1 <= cyc) begin
            e = qi.pop_front();
            tests++; fails++;
            $display("FAIL instr_missing_rvalid: got 0 expected 1 (cycle %0d)", cyc);
         end
         if (data_rvalid) begin
            tests++;
            if (qd.size() == 0) begin
               fails++;
               $display("FAIL data_spurious_rvalid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = qd.pop_front();
               if (cyc != e.gcyc + 1 || (e.chk && data_rdata !== e.val)) begin
                  fails++;
                  $display("FAIL data_resp: got %h@%0d expected %h@%0d", data_rdata, cyc, e.val, e.gcyc + 1);
               end
            end
         end else if (qd.size() > 0 && qd[0].gcyc + 1 <= cyc) begin
            e = qd.pop_front();
            tests++; fails++;
            $display("FAIL data_missing_rvalid: got 0 expected 1 (cycle %0d)", cyc);
         end
      end
   end

   // One stimulus cycle: drive at negedge, check grants, push expectations.
   task automatic drv(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic [AW-1:0] da, input logic dw,
                      input logic [3:0] db, input logic [31:0] dwd,
                      input logic eig, input logic edg,
                      input logic [31:0] eiv, input logic [31:0] edv, input logic dchk);
      exp_t e;
      @(negedge clk);
      instr_req = ir; instr_addr = ia;
      data_req = dr; data_addr = da; data_we = dw; data_be = db; data_wdata = dwd;
      #1;
      check("instr_gnt", {31'd0, instr_gnt}, {31'd0, eig});
      check("data_gnt", {31'd0, data_gnt}, {31'd0, edg});
      check("mem_en", {31'd0, mem_en}, {31'd0, eig | edg});
      if (eig) begin
         check("instr_mem_port", {mem_we, mem_be, 10'd0, mem_addr}, {1'b0, 4'hF, 10'd0, ia});
         e.chk = 1'b1; e.val = eiv; e.gcyc = cyc; qi.push_back(e);
      end else if (edg) begin
         check("data_mem_port", {mem_we, mem_be, 10'd0, mem_addr}, {dw, db, 10'd0, da});
         e.chk = dchk; e.val = edv; e.gcyc = cyc; qd.push_back(e);
      end else begin
         check("idle_mem_port", {mem_we, mem_be, 10'd0, mem_addr}, 32'd0);
      end
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cnt_after_edge(input string name, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check(name, conflict_cnt, exp);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
      for (int i = 0; i < 9; i++) ram[i] = (i + 1) * 32'h11;

      // Reset state
      #3;
      check("rst_instr_gnt", {31'd0, instr_gnt}, 32'd0);
      check("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
      check("rst_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      check("rst_cnt", conflict_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single requester: fetches 0x0..0xC
      drv(1, 22'h0, 0, 0, 0, 0, 0, 1, 0, 32'h11, 0, 0);
      drv(1, 22'h4, 0, 0, 0, 0, 0, 1, 0, 32'h22, 0, 0);
      drv(1, 22'h8, 0, 0, 0, 0, 0, 1, 0, 32'h33, 0, 0);
      drv(1, 22'hC, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 0);
      idle();
      check("cnt_no_conflict", conflict_cnt, 32'd0);

      // Contention: first tie after reset goes to instr, then alternates
      drv(1, 22'h14, 1, 22'h10, 0, 4'hF, 0, 1, 0, 32'h66, 0, 0);
      drv(1, 22'h18, 1, 22'h10, 0, 4'hF, 0, 0, 1, 0, 32'h55, 1);
      drv(1, 22'h18, 1, 22'h1C, 0, 4'hF, 0, 1, 0, 32'h77, 0, 0);
      drv(1, 22'h20, 1, 22'h1C, 0, 4'hF, 0, 0, 1, 0, 32'h88, 1);
      cnt_after_edge("cnt_after_4_ties", 32'd4);
      idle();

      // Write then fetch the same word
      drv(0, 0, 1, 22'h100, 1, 4'hF, 32'hDEADBEEF, 0, 1, 0, 0, 0);
      drv(1, 22'h100, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
      // Byte-enabled write, then data read
      drv(0, 0, 1, 22'h100, 1, 4'b0001, 32'h000000AA, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 22'h100, 0, 4'hF, 0, 0, 1, 0, 32'hDEADBEAA, 1);
      idle();

      // Saturation
      @(negedge clk);
      dut.conflict_cnt <= 32'hFFFF_FFFE;
      drv(1, 22'h0, 1, 22'h4, 0, 4'hF, 0, 1, 0, 32'h11, 0, 0);
      cnt_after_edge("cnt_sat_1", 32'hFFFF_FFFF);
      drv(1, 22'h4, 1, 22'h4, 0, 4'hF, 0, 0, 1, 0, 32'h22, 1);
      cnt_after_edge("cnt_sat_2", 32'hFFFF_FFFF);
      drv(1, 22'h4, 1, 22'h8, 0, 4'hF, 0, 1, 0, 32'h22, 0, 0);
      cnt_after_edge("cnt_sat_3", 32'hFFFF_FFFF);
      idle();

      // Reset mid-run with a data response in flight (last is INSTR here)
      drv(0, 0, 1, 22'h8, 0, 4'hF, 0, 0, 1, 0, 32'h33, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      qd.delete();
      idle();
      check("mid_rst_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      check("mid_rst_cnt", conflict_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      idle();
      // Tie after reset must go to instr again
      drv(1, 22'hC, 1, 22'h10, 0, 4'hF, 0, 1, 0, 32'h44, 0, 0);
      drv(0, 0, 1, 22'h10, 0, 4'hF, 0, 0, 1, 0, 32'h55, 1);
      cnt_after_edge("cnt_after_rst_tie", 32'd1);
      idle();
      idle();
      idle();

      check("instr_queue_drained", qi.size(), 32'd0);
      check("data_queue_drained", qd.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one single-port synchronous RAM between the RI5CY instruction-fetch and data LSU ports. Each cycle it grants at most one requester using round-robin arbitration, drives the RAM port from the granted side, and returns rvalid/rdata one cycle later to that side. It sits between the core and a single-port memory macro and replaces the dual-port arrangement when memory area matters more than bandwidth. It also counts arbitration conflicts for performance analysis.

## Interface
- ADDR_WIDTH, 22, word-aligned byte address width on all ports (4 MB space)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_gnt_o  out  1  fetch granted this cycle (combinational)
- instr_rvalid_o  out  1  fetch data valid (registered)
- instr_rdata_o  out  32  fetch data
- data_req_i  in  1  LSU request
- data_addr_i  in  ADDR_WIDTH  LSU address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU granted this cycle (combinational)
- data_rvalid_o  out  1  LSU response valid (registered), also for writes
- data_rdata_o  out  32  LSU read data
- mem_en_o, mem_addr_o[ADDR_WIDTH], mem_we_o, mem_be_o[4], mem_wdata_o[32]  out  RAM port
- mem_rdata_i  in  32  RAM read data, valid the cycle after mem_en_o
- conflict_cnt_o  out  32  count of cycles with both requests asserted

## Operation
- Arbitration state: `last` (1 bit, INSTR or DATA), the last side granted under contention. Reset value DATA, so the first tie goes to instr.
- Grant rules (combinational, same cycle as req):
  - Only one request asserted: grant it.
  - Both asserted: grant the side that is not `last`. Update `last` to the granted side at the clock edge.
  - Neither asserted: no grant, `last` unchanged.
- Grants with a single requester do not update `last`.
- The RAM port is driven from the granted side: mem_en_o = grant. Address, we, be and wdata come from that side.
- Instr grants drive mem_we_o = 0 and mem_be_o = 4'b1111.
- With no grant, mem_en_o = 0 and all other mem outputs are 0.
- Response pipeline: registers rv_instr and rv_data capture the grants. instr_rvalid_o = rv_instr; data_rvalid_o = rv_data. At most one of the two is high in any cycle.
- instr_rdata_o and data_rdata_o both carry mem_rdata_i unconditionally. The matching rvalid qualifies the data.
- conflict_cnt_o increments on every cycle in which both requests are high. It saturates at 32'hFFFF_FFFF.
- Requesters hold req/addr stable until they see gnt. The arbiter does not check this.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req). Response latency: rvalid exactly 1 cycle after gnt.
- Throughput: one access per cycle in total. Under sustained contention the two sides alternate 1:1, so the worst-case wait for either side is 1 cycle.
- Reset (asynchronous, any cycle) clears `last` to DATA, clears both rvalid registers and clears conflict_cnt_o to 0.
  - gnt outputs depend only on the current req inputs and `last`.
  - A response in flight when reset asserts is dropped; no rvalid is issued after reset.
- After reset deasserts, the first edge behaves as in normal operation.
- A write granted in cycle N gives data_rvalid_o in N+1, and the RAM holds the new data from N+1. An instr read of the same address granted in N+1 returns the new data in N+2.

## Test plan
- **Reset values:** assert rst mid-run with rv_data pending. All gnt/rvalid outputs are 0 while both reqs are 0, conflict_cnt_o = 0, and no rvalid appears after release.
- **Single requester:** instr_req held for 4 cycles at addresses 0x0, 0x4, 0x8, 0xC with RAM preloaded to 0x11..0x44. instr_gnt_o is high for 4 cycles and instr_rvalid_o follows one cycle later with rdata 0x11, 0x22, 0x33, 0x44. data_rvalid_o stays 0 throughout.
- **Contention tie after reset:** both reqs high in one cycle. instr granted first, then data next cycle, then instr, and so on. conflict_cnt_o increments each such cycle.
- **Write then fetch:** data write of 0xDEADBEEF with be = 4'b1111 to 0x100, then an instr read of 0x100. data_rvalid_o is high one cycle after the write grant, and instr_rdata_o = 0xDEADBEEF on its rvalid.
- **Byte enables:** word 0x100 = 0xDEADBEEF, then write 0x000000AA with be = 4'b0001, then a data read. data_rdata_o = 0xDEADBEAA.
- **Saturation:** force conflict_cnt_o to 0xFFFF_FFFE via a hierarchical deposit, then apply 3 contention cycles. The counter reads 0xFFFF_FFFF and stays there.
